// File: rtl/coherence_directory.sv
// coherence_directory
//   MSI directory controller. Holds a per-block state (Uncached/Shared/Modified)
//   and a sharer vector for NUM_PROCS processors. It serialises processor requests
//   one at a time, emits Invalidate / Fetch / FetchInvalidate / Reply messages over
//   a valid/ready channel, then writes the updated entry back and pulses Done.
// Ports
//   Clock, Reset_n                 clock, asynchronous active-low reset
//   ReqValid/ReqReady/ReqType/ReqProc/ReqAddr   request channel (accepted in IDLE)
//   MsgValid/MsgReady/MsgType/MsgDest/MsgAddr   outgoing message channel
//   AckValid/AckProc               data-return ack from the owner after a fetch
//   Done/DoneErr/DoneState/DoneShr retire pulse with the final entry contents
module coherence_directory #(
  parameter int NUM_PROCS = 4,
  parameter int PID_W     = 2,
  parameter int ADDR_W    = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic [1:0]           ReqType,
  input  logic [PID_W-1:0]     ReqProc,
  input  logic [ADDR_W-1:0]    ReqAddr,
  output logic                 MsgValid,
  input  logic                 MsgReady,
  output logic [2:0]           MsgType,
  output logic [PID_W-1:0]     MsgDest,
  output logic [ADDR_W-1:0]    MsgAddr,
  input  logic                 AckValid,
  input  logic [PID_W-1:0]     AckProc,
  output logic                 Done,
  output logic                 DoneErr,
  output logic [1:0]           DoneState,
  output logic [NUM_PROCS-1:0] DoneShr
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] REQ_RM  = 2'b00;
  localparam logic [1:0] REQ_WM  = 2'b01;
  localparam logic [1:0] REQ_WB  = 2'b10;
  localparam logic [1:0] REQ_UPG = 2'b11;

  localparam logic [2:0] MSG_NADA  = 3'b000;
  localparam logic [2:0] MSG_INV   = 3'b011;
  localparam logic [2:0] MSG_FETCH = 3'b100;
  localparam logic [2:0] MSG_REPLY = 3'b101;
  localparam logic [2:0] MSG_FINV  = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_INVAL, S_FETCH, S_WAIT_ACK, S_REPLY, S_UPDATE
  } state_e;

  typedef enum logic [1:0] {
    DIR_U = 2'b00, DIR_S = 2'b01, DIR_M = 2'b10
  } dir_e;

  state_e               state_q;
  dir_e                 dir_st_q  [DEPTH];
  logic [NUM_PROCS-1:0] dir_shr_q [DEPTH];

  logic [1:0]           type_q;
  logic [PID_W-1:0]     proc_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [PID_W-1:0]     owner_q;
  logic [NUM_PROCS-1:0] inv_q;
  dir_e                 nst_q;
  logic [NUM_PROCS-1:0] nshr_q;
  logic                 err_q;

  logic                 ReqReady_q, MsgValid_q, Done_q, DoneErr_q;
  logic [2:0]           MsgType_q;
  logic [PID_W-1:0]     MsgDest_q;
  logic [ADDR_W-1:0]    MsgAddr_q;
  logic [1:0]           DoneState_q;
  logic [NUM_PROCS-1:0] DoneShr_q;

  // Decision for the latched request against the current entry.
  dir_e                 cur_st;
  logic [NUM_PROCS-1:0] cur_shr, pbit;
  logic [PID_W-1:0]     dec_owner;
  dir_e                 st_d;
  logic [NUM_PROCS-1:0] shr_d, inv_d;
  logic                 err_d, fetch_d, finv_d, reply_d;

  function automatic logic [PID_W-1:0] lowest_idx(input logic [NUM_PROCS-1:0] v);
    logic found;
    lowest_idx = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      if (v[i] && !found) begin
        lowest_idx = PID_W'(i);
        found      = 1'b1;
      end
    end
  endfunction

  always_comb begin
    cur_st    = dir_st_q[addr_q];
    cur_shr   = dir_shr_q[addr_q];
    pbit      = NUM_PROCS'(1) << proc_q;
    dec_owner = lowest_idx(cur_shr);
    st_d      = cur_st;
    shr_d     = cur_shr;
    inv_d     = '0;
    err_d     = 1'b0;
    fetch_d   = 1'b0;
    finv_d    = 1'b0;
    reply_d   = 1'b1;
    case (type_q)
      REQ_RM: begin
        case (cur_st)
          DIR_S: begin st_d = DIR_S; shr_d = cur_shr | pbit; end
          DIR_M: begin
            if (dec_owner != proc_q) begin
              fetch_d = 1'b1;
              st_d    = DIR_S;
              shr_d   = cur_shr | pbit;
            end else begin
              st_d  = DIR_M;
              shr_d = pbit;
            end
          end
          default: begin st_d = DIR_S; shr_d = pbit; end
        endcase
      end
      REQ_WM, REQ_UPG: begin
        // Upgrade from a non-sharer behaves exactly like WriteMiss, so both
        // collapse to "invalidate every other sharer".
        st_d  = DIR_M;
        shr_d = pbit;
        if (cur_st == DIR_S) begin
          inv_d = cur_shr & ~pbit;
        end else if (cur_st == DIR_M && dec_owner != proc_q) begin
          fetch_d = 1'b1;
          finv_d  = 1'b1;
        end
      end
      default: begin  // REQ_WB
        reply_d = 1'b0;
        if (cur_st == DIR_M && dec_owner == proc_q) begin
          st_d  = DIR_U;
          shr_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dir_st_q[i]  <= DIR_U;
        dir_shr_q[i] <= '0;
      end
      type_q      <= REQ_RM;
      proc_q      <= '0;
      addr_q      <= '0;
      owner_q     <= '0;
      inv_q       <= '0;
      nst_q       <= DIR_U;
      nshr_q      <= '0;
      err_q       <= 1'b0;
      ReqReady_q  <= 1'b1;
      MsgValid_q  <= 1'b0;
      MsgType_q   <= MSG_NADA;
      MsgDest_q   <= '0;
      MsgAddr_q   <= '0;
      Done_q      <= 1'b0;
      DoneErr_q   <= 1'b0;
      DoneState_q <= '0;
      DoneShr_q   <= '0;
    end else begin
      Done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ReqValid) begin
            type_q     <= ReqType;
            proc_q     <= ReqProc;
            addr_q     <= ReqAddr;
            ReqReady_q <= 1'b0;
            state_q    <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          nst_q   <= st_d;
          nshr_q  <= shr_d;
          err_q   <= err_d;
          owner_q <= dec_owner;
          MsgAddr_q <= addr_q;
          if (inv_d != '0) begin
            MsgValid_q <= 1'b1;
            MsgType_q  <= MSG_INV;
            MsgDest_q  <= lowest_idx(inv_d);
            inv_q      <= inv_d & ~(NUM_PROCS'(1) << lowest_idx(inv_d));
            state_q    <= S_INVAL;
          end else if (fetch_d) begin
            MsgValid_q <= 1'b1;
            MsgType_q  <= finv_d ? MSG_FINV : MSG_FETCH;
            MsgDest_q  <= dec_owner;
            state_q    <= S_FETCH;
          end else if (reply_d) begin
            MsgValid_q <= 1'b1;
            MsgType_q  <= MSG_REPLY;
            MsgDest_q  <= proc_q;
            state_q    <= S_REPLY;
          end else begin
            state_q <= S_UPDATE;
          end
        end
        S_INVAL: begin
          // The next message is loaded on the same edge that consumes the
          // current one, so invalidates go out back-to-back.
          if (MsgReady) begin
            if (inv_q != '0) begin
              MsgDest_q <= lowest_idx(inv_q);
              inv_q     <= inv_q & ~(NUM_PROCS'(1) << lowest_idx(inv_q));
            end else begin
              MsgType_q <= MSG_REPLY;
              MsgDest_q <= proc_q;
              state_q   <= S_REPLY;
            end
          end
        end
        S_FETCH: begin
          if (MsgReady) begin
            MsgValid_q <= 1'b0;
            MsgType_q  <= MSG_NADA;
            state_q    <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (AckValid && AckProc == owner_q) begin
            MsgValid_q <= 1'b1;
            MsgType_q  <= MSG_REPLY;
            MsgDest_q  <= proc_q;
            state_q    <= S_REPLY;
          end
        end
        S_REPLY: begin
          if (MsgReady) begin
            MsgValid_q <= 1'b0;
            MsgType_q  <= MSG_NADA;
            state_q    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!err_q) begin
            dir_st_q[addr_q]  <= nst_q;
            dir_shr_q[addr_q] <= nshr_q;
          end
          Done_q      <= 1'b1;
          DoneErr_q   <= err_q;
          DoneState_q <= nst_q;
          DoneShr_q   <= nshr_q;
          ReqReady_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReqReady  = ReqReady_q;
  assign MsgValid  = MsgValid_q;
  assign MsgType   = MsgType_q;
  assign MsgDest   = MsgDest_q;
  assign MsgAddr   = MsgAddr_q;
  assign Done      = Done_q;
  assign DoneErr   = DoneErr_q;
  assign DoneState = DoneState_q;
  assign DoneShr   = DoneShr_q;

endmodule
